// File: rtl/mc_maindec_if.sv
// ----------------------------------------------------------------------------
// mc_maindec_if
//
// Bundle between the multicycle main decoder and the datapath it steers.
//
//   op       [5:0]  instr[31:26] from the instruction register  (datapath -> dec)
//   zero            ALU zero flag                               (datapath -> dec)
//   iord            memory address select: 0 = PC, 1 = ALUOut
//   irwrite         instruction register load
//   memwrite        data memory write strobe
//   regwrite        register file write strobe
//   regdst          write-register select: 0 = rt, 1 = rd
//   memtoreg        write-back select: 0 = ALUOut, 1 = memory data
//   alusrca         ALU A select: 0 = PC, 1 = register A
//   alusrcb  [1:0]  ALU B select: 00 B, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc    [1:0]  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target
//   aluop    [1:0]  ALU op class: 00 add, 01 sub, 10 funct-decoded
//   pcen            PC load enable
//
// Modports: master = the decoder (drives controls), slave = the datapath.
// ----------------------------------------------------------------------------
interface mc_maindec_if;
    logic [5:0] op;
    logic       zero;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcen;

    modport master (
        input  op, zero,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, aluop, pcen
    );

    modport slave (
        output op, zero,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, aluop, pcen
    );
endinterface

// File: rtl/mc_maindec.sv
// ----------------------------------------------------------------------------
// mc_maindec
//
// Main control FSM of a multicycle MIPS-style processor. A Moore machine
// that sequences each instruction through fetch, decode and its execute /
// memory / write-back steps, driving the datapath mux selects and write
// strobes. All controls except pcen are registered; pcen also folds in the
// live ALU zero flag so a taken branch loads the PC in BEQEX itself.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (forces FETCH)
//   bus    mc_maindec_if.master   op/zero in, datapath controls out
//   state  out  [3:0] current state code, for debug
//
// Build option
//   MC_MAINDEC_J_EN  when defined, opcode 000010 (J) runs through JEX (code
//                    11). When undefined, J is decoded as an illegal opcode
//                    and code 11 behaves like the other unused codes.
//
// Cycles per instruction, FETCH inclusive:
//   LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
// ----------------------------------------------------------------------------
module mc_maindec (
    input  logic          clk,
    input  logic          reset,
    mc_maindec_if.master  bus,
    output logic [3:0]    state
);

    // ------------------------------------------------------------------------
    // State encoding (codes are visible on the debug port, so fixed).
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
`ifdef MC_MAINDEC_J_EN
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`else
        ADDIWB  = 4'd10
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // Opcodes (instr[31:26]).
    // ------------------------------------------------------------------------
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_MAINDEC_J_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    // ------------------------------------------------------------------------
    // Control word. pcwrite and branch stay internal; they only feed pcen.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctl_t;

    // Moore output table: the controls that belong to each state. Unused
    // codes (12-15, and 11 without J support) fall to the all-zero default.
    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = 2'b01;   // PC + 4
                c.pcwrite = 1'b1;
            end
            DECODE: begin
                c.alusrcb = 2'b11;   // precompute branch target
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;   // base + signimm
            end
            MEMRD: begin
                c.iord = 1'b1;
            end
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;   // subtract for the compare
                c.pcsrc   = 2'b01;   // target computed in DECODE
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB: begin
                c.regwrite = 1'b1;
            end
`ifdef MC_MAINDEC_J_EN
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t cur_state;
    state_t nxt_state;
    ctl_t   ctl;

    // ------------------------------------------------------------------------
    // Next-state logic. op is only looked at in DECODE and MEMADR, so the
    // instruction register may change freely in every other state.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: assign a default before the case so every path drives
        // nxt_state; a missed path would otherwise infer a latch.
        nxt_state = FETCH;
        case (cur_state)
            FETCH:   nxt_state = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_RTYPE:     nxt_state = RTYPEEX;
                    OP_BEQ:       nxt_state = BEQEX;
                    OP_ADDI:      nxt_state = ADDIEX;
`ifdef MC_MAINDEC_J_EN
                    OP_J:         nxt_state = JEX;
`endif
                    // Illegal opcode: straight back to FETCH, nothing written.
                    default:      nxt_state = FETCH;
                endcase
            end
            MEMADR: begin
                // Only LW/SW reach here; if op was disturbed to anything
                // else, abandon the access rather than write memory.
                case (bus.op)
                    OP_LW:   nxt_state = MEMRD;
                    OP_SW:   nxt_state = MEMWR;
                    default: nxt_state = FETCH;
                endcase
            end
            MEMRD:   nxt_state = MEMWB;
            RTYPEEX: nxt_state = RTYPEWB;
            ADDIEX:  nxt_state = ADDIWB;
            // MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX and unused codes.
            default: nxt_state = FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and registered outputs. The control word is loaded from the
    // state being entered, so it always matches cur_state with no decode
    // delay after the edge. Reset holds FETCH and FETCH's controls.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked logic so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            cur_state <= FETCH;
            ctl       <= ctl_for(FETCH);
        end else begin
            cur_state <= nxt_state;
            ctl       <= ctl_for(nxt_state);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------------
    assign state        = cur_state;
    assign bus.iord     = ctl.iord;
    assign bus.irwrite  = ctl.irwrite;
    assign bus.memwrite = ctl.memwrite;
    assign bus.regwrite = ctl.regwrite;
    assign bus.regdst   = ctl.regdst;
    assign bus.memtoreg = ctl.memtoreg;
    assign bus.alusrca  = ctl.alusrca;
    assign bus.alusrcb  = ctl.alusrcb;
    assign bus.pcsrc    = ctl.pcsrc;
    assign bus.aluop    = ctl.aluop;

    // Zero comes from the ALU in the same cycle, so the branch decision is
    // combinational on top of the registered branch flag.
    assign bus.pcen = ctl.pcwrite | (ctl.branch & bus.zero);

endmodule

// File: tb/tb_mc_maindec.sv
// ----------------------------------------------------------------------------
// tb_mc_maindec
//
// Directed bench for mc_maindec: walks each instruction class through its
// state sequence and compares the state code and the full control vector
// against hand-computed values. Build with or without MC_MAINDEC_J_EN.
// ----------------------------------------------------------------------------
module tb_mc_maindec;

    // Control vector layout:
    // [13] iord [12] irwrite [11] memwrite [10] regwrite [9] regdst
    // [8] memtoreg [7] alusrca [6:5] alusrcb [4:3] pcsrc [2:1] aluop [0] pcen
    localparam logic [13:0] C_FETCH   = 14'b0_1_0_0_0_0_0_01_00_00_1;
    localparam logic [13:0] C_DECODE  = 14'b0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [13:0] C_MEMADR  = 14'b0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [13:0] C_MEMRD   = 14'b1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [13:0] C_MEMWB   = 14'b0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [13:0] C_MEMWR   = 14'b1_0_1_0_0_0_0_00_00_00_0;
    localparam logic [13:0] C_RTYPEEX = 14'b0_0_0_0_0_0_1_00_00_10_0;
    localparam logic [13:0] C_RTYPEWB = 14'b0_0_0_1_1_0_0_00_00_00_0;
    localparam logic [13:0] C_BEQ_Z1  = 14'b0_0_0_0_0_0_1_00_01_01_1;
    localparam logic [13:0] C_BEQ_Z0  = 14'b0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [13:0] C_ADDIEX  = 14'b0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [13:0] C_ADDIWB  = 14'b0_0_0_1_0_0_0_00_00_00_0;
`ifdef MC_MAINDEC_J_EN
    localparam logic [13:0] C_JEX     = 14'b0_0_0_0_0_0_0_00_10_00_1;
`endif

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       clk;
    logic       reset;
    logic [3:0] state;
    int         checks = 0;
    int         errors = 0;

    mc_maindec_if bus ();

    mc_maindec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is a few dozen cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] ctlv();
        return {bus.iord, bus.irwrite, bus.memwrite, bus.regwrite, bus.regdst,
                bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop,
                bus.pcen};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check state code and full control vector together.
    task automatic check_sc(input string tag, input logic [3:0] exp_state,
                            input logic [13:0] exp_ctl);
        check({tag, "_state"}, {28'd0, state}, {28'd0, exp_state});
        check({tag, "_ctl"}, {18'd0, ctlv()}, {18'd0, exp_ctl});
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        bus.op  = OP_LW;
        bus.zero = 1'b0;

        // ---- reset holds FETCH, op changes ignored ----
        step();
        step();
        check_sc("rst_hold", 4'd0, C_FETCH);
        bus.op = OP_BAD;
        step();
        check_sc("rst_hold2", 4'd0, C_FETCH);

        // ---- LW: 0,1,2,3,4,0 ----
        reset  = 1'b0;
        bus.op = OP_LW;
        step(); check_sc("lw_decode", 4'd1, C_DECODE);
        step(); check_sc("lw_memadr", 4'd2, C_MEMADR);
        step(); check_sc("lw_memrd",  4'd3, C_MEMRD);
        // op changes outside DECODE/MEMADR must not disturb the sequence
        bus.op = OP_SW;
        step(); check_sc("lw_memwb",  4'd4, C_MEMWB);
        check("lw_memwb_memwrite", {31'd0, bus.memwrite}, 32'd0);
        step(); check_sc("lw_fetch",  4'd0, C_FETCH);

        // ---- SW: 0,1,2,5,0 ----
        bus.op = OP_SW;
        step(); check_sc("sw_decode", 4'd1, C_DECODE);
        step(); check_sc("sw_memadr", 4'd2, C_MEMADR);
        step(); check_sc("sw_memwr",  4'd5, C_MEMWR);
        step(); check_sc("sw_fetch",  4'd0, C_FETCH);

        // ---- R-type: 0,1,6,7,0, op change in RTYPEEX ignored ----
        bus.op = OP_RTYPE;
        step(); check_sc("r_decode",  4'd1, C_DECODE);
        step(); check_sc("r_ex",      4'd6, C_RTYPEEX);
        bus.op = OP_LW;
        step(); check_sc("r_wb",      4'd7, C_RTYPEWB);
        step(); check_sc("r_fetch",   4'd0, C_FETCH);

        // ---- BEQ: 0,1,8,0 with zero=1 then zero=0 in BEQEX ----
        bus.op   = OP_BEQ;
        bus.zero = 1'b1;
        step(); check_sc("beq_decode", 4'd1, C_DECODE);
        step(); check_sc("beq_ex_z1",  4'd8, C_BEQ_Z1);
        bus.zero = 1'b0;
        #1;
        check_sc("beq_ex_z0", 4'd8, C_BEQ_Z0);
        step(); check_sc("beq_fetch",  4'd0, C_FETCH);

        // ---- ADDI: 0,1,9,10,0 ----
        bus.op = OP_ADDI;
        step(); check_sc("addi_decode", 4'd1, C_DECODE);
        step(); check_sc("addi_ex",     4'd9, C_ADDIEX);
        step(); check_sc("addi_wb",     4'd10, C_ADDIWB);
        step(); check_sc("addi_fetch",  4'd0, C_FETCH);

        // ---- illegal opcode: 0,1,0, no writes ----
        bus.op = OP_BAD;
        step(); check_sc("ill_decode", 4'd1, C_DECODE);
        check("ill_decode_wr", {30'd0, bus.regwrite, bus.memwrite}, 32'd0);
        step(); check_sc("ill_fetch",  4'd0, C_FETCH);
        check("ill_fetch_wr", {30'd0, bus.regwrite, bus.memwrite}, 32'd0);

        // ---- reset mid-instruction (in MEMRD) ----
        bus.op = OP_LW;
        step(); step(); step();
        check_sc("mid_memrd", 4'd3, C_MEMRD);
        reset = 1'b1;
        step(); check_sc("mid_rst", 4'd0, C_FETCH);
        check("mid_rst_irwrite", {31'd0, bus.irwrite}, 32'd1);
        reset = 1'b0;
        step(); check_sc("mid_first", 4'd1, C_DECODE);
        bus.op = OP_BAD;
        step(); check_sc("mid_back", 4'd0, C_FETCH);

        // ---- J ----
        bus.op = OP_J;
        step(); check_sc("j_decode", 4'd1, C_DECODE);
        step();
`ifdef MC_MAINDEC_J_EN
        check_sc("j_ex", 4'd11, C_JEX);
        step();
`endif
        check_sc("j_fetch", 4'd0, C_FETCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  synchronous active-high reset.
REQ-004 SHALL have port: op  in  6  instr[31:26] from the instruction register.
REQ-005 SHALL have port: zero  in  1  ALU zero flag.
REQ-006 SHALL have ports: iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca (each out 1).
- All are multicycle datapath controls with their usual meanings.
REQ-007 SHALL have ports: alusrcb  out  2  and  pcsrc  out  2  (datapath mux selects).
REQ-008 SHALL have port: aluop  out  2  ALU op class for the ALU decoder: 00 add, 01 sub, 10 funct-decoded.
REQ-009 SHALL have port: pcen  out  1  PC load enable.
REQ-010 SHALL have port: state  out  4  current state code, for debug.

Function
REQ-011 SHALL be a Moore FSM with these state codes:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
- RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11
REQ-012 SHALL use these opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
REQ-013 SHALL follow these transitions:
- FETCH->DECODE
- DECODE->MEMADR (LW/SW), RTYPEEX, BEQEX, ADDIEX, JEX, by op
- MEMADR->MEMRD (LW) or MEMWR (SW)
- MEMRD->MEMWB, RTYPEEX->RTYPEWB, ADDIEX->ADDIWB
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH
REQ-014 SHALL go DECODE->FETCH for any unlisted op (illegal opcode), with no register or memory write.
REQ-015 SHALL sample op only in DECODE and MEMADR; op changes in other states SHALL have no effect.
REQ-016 SHALL drive these per-state outputs (every unlisted output 0):
- FETCH: irwrite=1, alusrcb=01, pcwrite=1
- DECODE: alusrcb=11
- MEMADR: alusrca=1, alusrcb=10
- MEMRD: iord=1
- MEMWB: memtoreg=1, regwrite=1
- MEMWR: iord=1, memwrite=1
- RTYPEEX: alusrca=1, aluop=10
- RTYPEWB: regdst=1, regwrite=1
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1
- ADDIEX: alusrca=1, alusrcb=10
- ADDIWB: regwrite=1
- JEX: pcsrc=10, pcwrite=1
REQ-017 SHALL compute pcen = pcwrite | (branch & zero) combinationally, where pcwrite and branch are internal.
REQ-018 SHALL take these cycles per instruction, FETCH inclusive: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
REQ-019 SHALL treat codes 12-15 as unused: all outputs 0 and next state FETCH.

Reset
REQ-020 SHALL load state FETCH on any rising clk edge with reset=1, from any state including mid-instruction.
REQ-021 SHALL hold FETCH while reset is asserted, so outputs show FETCH values (irwrite=1, pcwrite=1, pcen=1, alusrcb=01, others 0).
REQ-022 SHALL make the first non-reset edge go FETCH->DECODE.

Configuration
REQ-023 SHALL compile in J support when MC_MAINDEC_J_EN is defined: op 000010 goes DECODE->JEX.
REQ-024 SHALL make op 000010 illegal when MC_MAINDEC_J_EN is undefined (DECODE->FETCH), with JEX removed and code 11 handled as unused.

Verification
REQ-025 SHALL check LW: reset, then op=100011 -> states 0,1,2,3,4,0; MEMWB has regwrite=1, memtoreg=1; memwrite=0 throughout.
REQ-026 SHALL check BEQ: op=000100 -> states 0,1,8,0; in BEQEX, zero=1 gives pcen=1, pcsrc=01, aluop=01; zero=0 gives pcen=0.
REQ-027 SHALL check R-type: op=000000 -> state 6 drives aluop=10, alusrca=1, alusrcb=00; state 7 drives regdst=1, regwrite=1.
REQ-028 SHALL check illegal opcode: op=111111 in DECODE -> next state 0; regwrite=memwrite=0 across both cycles.
REQ-029 SHALL check reset mid-operation: reset=1 while in MEMRD (3) -> state 0 on that edge; irwrite=1 next cycle.
REQ-030 SHALL check J: op=000010 -> with MC_MAINDEC_J_EN, states 0,1,11,0 and pcsrc=10, pcen=1 in JEX; without it, states 0,1,0.
